mul_share_arbiter: RTL and testbench

- Shares one sequential 8x8 multiplier (binary_multiplier: start/Ready handshake, variable latency with early termination) between N requesters.
- Round-robin arbitration; latches the winner's operands and drives the multiplier's start.
- Tracks the multiplier's Ready low-then-high cycle, captures the product and returns it to the owning requester with a one-cycle done pulse.
- A watchdog flags a multiplier that never completes.

---
 rtl/mul_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one sequential 8x8 multiplier among N requesters,
// with per-job watchdog. Rev 1.0
`default_nettype none

module mul_share_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] opa,
  input  logic [8*N-1:0] opb,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [N-1:0]   err,
  output logic [15:0]    result,
  output logic           busy,
  output logic           mul_start,
  output logic [7:0]     mul_a,
  output logic [7:0]     mul_b,
  input  logic [15:0]    mul_product,
  input  logic           mul_ready
);

  localparam int PW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT_LO = 2'd2;
  localparam logic [1:0] S_WAIT_HI = 2'd3;

  localparam logic [N-1:0]  ONE_N     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic [N-1:0]  err_q, err_d;
  logic [15:0]   result_q, result_d;
  logic          mul_start_q, mul_start_d;
  logic [7:0]    mul_a_q, mul_a_d;
  logic [7:0]    mul_b_q, mul_b_d;

  logic [PW-1:0] scan_idx;
  logic [PW-1:0] winner;
  logic          found;
  logic [N-1:0]  owner_oh;
  logic          wdog_expired;

  // First requesting index at or after ptr, wrapping modulo N.
  always_comb begin
    scan_idx = '0;
    winner   = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  assign owner_oh     = ONE_N << owner_q;
  assign wdog_expired = (wdog_q == WDOG_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wdog_d      = wdog_q;
    grant_d     = '0;
    done_d      = '0;
    err_d       = '0;
    result_d    = result_q;
    mul_start_d = mul_start_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    case (state_q)
      S_IDLE: begin
        if (found && mul_ready) begin
          owner_d     = winner;
          grant_d     = ONE_N << winner;
          mul_a_d     = opa[8*int'(winner) +: 8];
          mul_b_d     = opb[8*int'(winner) +: 8];
          mul_start_d = 1'b1;
          ptr_d       = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        mul_start_d = 1'b0;
        wdog_d      = '0;
        state_d     = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!mul_ready) begin
          state_d = S_WAIT_HI;
        end else if (wdog_expired) begin
          err_d   = owner_oh;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (mul_ready) begin
          result_d = mul_product;
          done_d   = owner_oh;
          state_d  = S_IDLE;
        end else if (wdog_expired) begin
          err_d   = owner_oh;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wdog_q      <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wdog_q      <= wdog_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign busy      = (state_q != S_IDLE);
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed checks of mul_share_arbiter against a behavioural multiplier.
// Rev 1.0
`default_nettype none

module tb_mul_share_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 32;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] opa;
  logic [8*N-1:0] opb;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic [15:0]    result;
  logic           busy;
  logic           mul_start;
  logic [7:0]     mul_a;
  logic [7:0]     mul_b;
  logic [15:0]    mul_product;
  logic           mul_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mul_share_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .opa         (opa),
    .opb         (opb),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .result      (result),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_ready   (mul_ready)
  );

  always #5 clock = ~clock;

  // Multiplier model: 16 busy cycles, 2 when either operand is zero; stub mode never goes busy.
  logic stub_stuck;
  int   m_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_ready   <= 1'b1;
      m_cnt       <= 0;
      mul_product <= 16'd0;
    end else if (stub_stuck) begin
      mul_ready <= 1'b1;
    end else if (mul_start && mul_ready) begin
      mul_ready   <= 1'b0;
      m_cnt       <= (mul_a == 8'd0 || mul_b == 8'd0) ? 2 : 16;
      mul_product <= {8'd0, mul_a} * {8'd0, mul_b};
    end else if (!mul_ready) begin
      if (m_cnt == 1) mul_ready <= 1'b1;
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(output int cyc, output logic [N-1:0] g, output logic [N-1:0] seen);
    cyc  = 0;
    seen = '0;
    while (grant == '0 && cyc < 100) begin
      tick();
      cyc++;
      seen = seen | done | err;
    end
    g = grant;
  endtask

  task automatic wait_done(output int cyc, output logic [N-1:0] d, output logic [N-1:0] e);
    cyc = 0;
    while (done == '0 && err == '0 && cyc < 100) begin
      tick();
      cyc++;
    end
    d = done;
    e = err;
  endtask

  task automatic test_reset();
    n_tests++;
    if (grant !== 4'b0 || done !== 4'b0 || err !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: grant=%b done=%b err=%b, required all 0", grant, done, err);
    end
    n_tests++;
    if (result !== 16'd0 || busy !== 1'b0 || mul_start !== 1'b0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: result=%0d busy=%b start=%b a=%0d b=%0d, required all 0",
               result, busy, mul_start, mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    int cyc;
    logic [N-1:0] g, d, e, s;
    opa[7:0] = 8'd13;
    opb[7:0] = 8'd11;
    req      = 4'b0001;
    wait_grant(cyc, g, s);
    req = '0;
    n_tests++;
    if (g !== 4'b0001 || mul_start !== 1'b1 || mul_a !== 8'd13 || mul_b !== 8'd11) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b start=%b a=%0d b=%0d, required 0001 1 13 11", g, mul_start, mul_a, mul_b);
    end
    tick();
    n_tests++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_grant_pulse: grant=%b, required 0000", grant);
    end
    wait_done(cyc, d, e);
    n_tests++;
    if (d !== 4'b0001 || e !== 4'b0000 || cyc + 1 != 18) begin
      n_fail++;
      $display("FAIL single_done: done=%b err=%b latency=%0d, required 0001 0000 18", d, e, cyc + 1);
    end
    n_tests++;
    if (result !== 16'd143 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: result=%0d busy=%b, required 143 0", result, busy);
    end
  endtask

  task automatic test_zero();
    int cyc;
    logic [N-1:0] g, d, e, s;
    opa[23:16] = 8'd0;
    opb[23:16] = 8'd200;
    req        = 4'b0100;
    wait_grant(cyc, g, s);
    req = '0;
    n_tests++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL zero_grant: grant=%b, required 0100", g);
    end
    wait_done(cyc, d, e);
    n_tests++;
    if (d !== 4'b0100 || result !== 16'd0 || cyc != 4) begin
      n_fail++;
      $display("FAIL zero_done: done=%b result=%0d latency=%0d, required 0100 0 4", d, result, cyc);
    end
  endtask

  task automatic test_fairness();
    int cyc;
    int exp_id;
    logic [N-1:0] g, d, e, s;
    logic [15:0] exp_res;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      opa[8*i +: 8] = 8'(i * 17);
      opb[8*i +: 8] = 8'd3;
    end
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_id  = j % N;
      exp_res = 16'(exp_id * 51);
      wait_grant(cyc, g, s);
      if (j == 4) req = '0;
      n_tests++;
      if (g !== (4'b0001 << exp_id) || (j > 0 && cyc != 1)) begin
        n_fail++;
        $display("FAIL fair_grant%0d: grant=%b gap=%0d, required %b 1", j, g, cyc, 4'b0001 << exp_id);
      end
      wait_done(cyc, d, e);
      n_tests++;
      if (d !== (4'b0001 << exp_id) || result !== exp_res) begin
        n_fail++;
        $display("FAIL fair_done%0d: done=%b result=%0d, required %b %0d", j, d, result, 4'b0001 << exp_id, exp_res);
      end
    end
  endtask

  task automatic test_max();
    int cyc;
    logic [N-1:0] g, d, e, s;
    opa[31:24] = 8'd255;
    opb[31:24] = 8'd255;
    req        = 4'b1000;
    wait_grant(cyc, g, s);
    req = '0;
    n_tests++;
    if (g !== 4'b1000) begin
      n_fail++;
      $display("FAIL max_grant: grant=%b, required 1000", g);
    end
    wait_done(cyc, d, e);
    n_tests++;
    if (d !== 4'b1000 || result !== 16'hFE01 || busy !== 1'b0 || cyc != 18) begin
      n_fail++;
      $display("FAIL max_done: done=%b result=%h busy=%b latency=%0d, required 1000 fe01 0 18", d, result, busy, cyc);
    end
    repeat (3) tick();
    n_tests++;
    if (result !== 16'hFE01 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL max_hold: result=%h done=%b, required fe01 0000", result, done);
    end
  endtask

  task automatic test_watchdog();
    int cyc;
    logic [N-1:0] g, d, e, s;
    stub_stuck = 1'b1;
    opa[15:8]  = 8'd7;
    opb[15:8]  = 8'd9;
    req        = 4'b0010;
    wait_grant(cyc, g, s);
    req = '0;
    n_tests++;
    if (g !== 4'b0010) begin
      n_fail++;
      $display("FAIL wdog_grant: grant=%b, required 0010", g);
    end
    wait_done(cyc, d, e);
    n_tests++;
    if (e !== 4'b0010 || d !== 4'b0000 || cyc != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL wdog_err: err=%b done=%b latency=%0d, required 0010 0000 %0d", e, d, cyc, TIMEOUT + 1);
    end
    n_tests++;
    if (result !== 16'hFE01 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_result: result=%h busy=%b, required fe01 0", result, busy);
    end
    stub_stuck = 1'b0;
    opa[23:16] = 8'd5;
    opb[23:16] = 8'd6;
    req        = 4'b0100;
    wait_grant(cyc, g, s);
    req = '0;
    wait_done(cyc, d, e);
    n_tests++;
    if (g !== 4'b0100 || d !== 4'b0100 || result !== 16'd30 || cyc != 18) begin
      n_fail++;
      $display("FAIL wdog_recover: grant=%b done=%b result=%0d latency=%0d, required 0100 0100 30 18", g, d, result, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [N-1:0] g, d, e, s;
    opa[15:8] = 8'd20;
    opb[15:8] = 8'd20;
    req       = 4'b0010;
    wait_grant(cyc, g, s);
    req = '0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (grant !== 4'b0 || done !== 4'b0 || err !== 4'b0 || busy !== 1'b0 || mul_start !== 1'b0 ||
        mul_a !== 8'd0 || mul_b !== 8'd0 || result !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_async: grant=%b done=%b err=%b busy=%b start=%b a=%0d b=%0d result=%0d, required all 0",
               grant, done, err, busy, mul_start, mul_a, mul_b, result);
    end
    opa[31:24] = 8'd1;
    opb[31:24] = 8'd1;
    req        = 4'b1010;
    tick();
    tick();
    reset = 1'b0;
    wait_grant(cyc, g, s);
    req = '0;
    n_tests++;
    if (g !== 4'b0010 || s !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_regrant: grant=%b stray_done_err=%b, required 0010 0000", g, s);
    end
    wait_done(cyc, d, e);
    n_tests++;
    if (d !== 4'b0010 || result !== 16'd400) begin
      n_fail++;
      $display("FAIL midreset_done: done=%b result=%0d, required 0010 400", d, result);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    opa        = '0;
    opb        = '0;
    stub_stuck = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    tick();
    test_single();
    test_zero();
    test_fairness();
    test_max();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
